// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter
// Round-robin arbiter that drives the select of a shared 16:1 mux and a
// one-hot grant. A tenure ends when the owner pulses done, when the owner
// drops its request, or when the hold limit is reached. Every release is
// followed by a one-cycle dead gap (REL) and then a cycle in IDLE, where the
// next owner is picked.
//
// Handshake: req is level-held by each requester. A requester owns the mux
// while gnt[i]=1. It may end its tenure early with a one-cycle done pulse or
// by dropping req[i]. Otherwise the arbiter force-releases it after MAX_HOLD
// cycles and flags this with a one-cycle timeout pulse. sel changes only when
// a new grant is issued, so the owner always sees a stable mux path.
module mux16_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_REL   = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  ptr_q;
  logic [3:0]  sel_q;
  logic [15:0] gnt_q;
  logic        busy_q;
  logic        timeout_q;
  logic [7:0]  hold_q;

  logic [3:0]  pick_idx;
  logic [3:0]  cand;
  logic        any_req;
  logic        own_req;
  logic        hold_hit;
  logic        release_now;

  // Circular priority scan: the lowest offset from ptr_q with a set request
  // wins. Scanning from the highest offset down lets the nearest one overwrite.
  always_comb begin
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int k = 15; k >= 0; k--) begin
      cand = ptr_q + 4'(k);
      if (req[cand]) begin
        pick_idx = cand;
      end
    end
  end

  assign any_req     = |req;
  assign own_req     = req[sel_q];
  assign hold_hit    = (hold_q == 8'(MAX_HOLD - 1));
  assign release_now = done | ~own_req | hold_hit;

  // Arbitration FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 4'd0;
      sel_q     <= 4'd0;
      gnt_q     <= 16'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timeout_q <= 1'b0;
          if (any_req) begin
            state_q <= S_GRANT;
            sel_q   <= pick_idx;
            gnt_q   <= 16'd1 << pick_idx;
            busy_q  <= 1'b1;
            hold_q  <= 8'd0;
          end
        end
        S_GRANT: begin
          hold_q <= hold_q + 8'd1;
          if (release_now) begin
            state_q   <= S_REL;
            gnt_q     <= 16'd0;
            busy_q    <= 1'b0;
            ptr_q     <= sel_q + 4'd1;
            // done and req-drop take precedence over the hold limit
            timeout_q <= hold_hit & ~done & own_req;
          end
        end
        S_REL: begin
          timeout_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q   <= S_IDLE;
          gnt_q     <= 16'd0;
          busy_q    <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Bench for mux16_rr_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic, all checked against a cycle model.
module tb_mux16_rr_arbiter;

  localparam int MAX_HOLD = 8;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        timeout;
  logic [1:0]  dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mux16_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [21:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks who owns the mux, how long they've held it, and whether the dead
  // gap after a release is in progress. Winner choice = smallest circular
  // distance from the pointer.
  int m_owner = -1;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_ten   = 0;
  bit m_gap   = 0;
  bit m_to    = 0;

  task automatic model_step(input logic r, input logic [15:0] rq, input logic d);
    int best;
    bit lim;
    if (r) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_ten = 0; m_gap = 0; m_to = 0;
    end else if (m_owner >= 0) begin
      m_to = 0;
      lim  = (m_ten == MAX_HOLD - 1);
      if (d || !rq[m_owner] || lim) begin
        m_to    = lim && !d && rq[m_owner];
        m_ptr   = (m_owner + 1) % 16;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_ten++;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_to  = 0;
    end else begin
      m_to = 0;
      best = -1;
      for (int i = 0; i < 16; i++) begin
        if (rq[i] && (best < 0 || ((i - m_ptr + 16) % 16) < ((best - m_ptr + 16) % 16)))
          best = i;
      end
      if (best >= 0) begin
        m_owner = best;
        m_sel   = best;
        m_ten   = 0;
      end
    end
    exp_q.push_back({4'(m_sel),
                     (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0,
                     (m_owner >= 0) ? 1'b1 : 1'b0,
                     m_to});
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 time unit after a rising edge; outputs are compared at
  // the same point, after the model has seen the same edge.
  task automatic step(input logic r, input logic [15:0] rq, input logic d);
    logic [21:0] e;
    rst  = r;
    req  = rq;
    done = d;
    @(posedge clk);
    model_step(r, rq, d);
    #1;
    e = exp_q.pop_front();
    check("model", {10'd0, sel, gnt, busy, timeout}, {10'd0, e});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r;
    logic [15:0] rq;
    logic        d;
    logic [3:0]  e_sel;
    logic [15:0] e_gnt;
    logic        e_busy;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [15:0] rq, input logic d,
                              input logic [3:0] es, input logic [15:0] eg,
                              input logic eb, input logic et);
    vec_t v;
    v.r = r; v.rq = rq; v.d = d;
    v.e_sel = es; v.e_gnt = eg; v.e_busy = eb; v.e_to = et;
    vecs.push_back(v);
  endfunction

  initial begin
    rst  = 1'b1;
    req  = 16'd0;
    done = 1'b0;

    // reset, then idle with no requests
    add(1, 16'h0000, 0, 4'd0, 16'h0000, 0, 0);
    add(1, 16'h0000, 0, 4'd0, 16'h0000, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 0, 4'd0, 16'h0000, 0, 0);
    // single requester 2, released by done
    add(0, 16'h0004, 0, 4'd2, 16'h0004, 1, 0);
    add(0, 16'h0004, 0, 4'd2, 16'h0004, 1, 0);
    add(0, 16'h0004, 1, 4'd2, 16'h0000, 0, 0);
    add(0, 16'h0000, 0, 4'd2, 16'h0000, 0, 0);
    // pointer is now 3: with 2 and 3 requesting, 3 wins
    add(0, 16'h000C, 0, 4'd3, 16'h0008, 1, 0);
    // owner drops its request: plain release, no timeout
    add(0, 16'h0000, 0, 4'd3, 16'h0000, 0, 0);
    add(0, 16'h0000, 0, 4'd3, 16'h0000, 0, 0);
    // requester 5 holds with no done: 8 granted cycles, then timeout pulse
    for (int i = 0; i < MAX_HOLD; i++) add(0, 16'h0020, 0, 4'd5, 16'h0020, 1, 0);
    add(0, 16'h0020, 0, 4'd5, 16'h0000, 0, 1);
    add(0, 16'h0020, 0, 4'd5, 16'h0000, 0, 0);
    add(0, 16'h0020, 0, 4'd5, 16'h0020, 1, 0);
    // done on the limit cycle: done wins, no timeout
    for (int i = 0; i < MAX_HOLD - 1; i++) add(0, 16'h0020, 0, 4'd5, 16'h0020, 1, 0);
    add(0, 16'h0020, 1, 4'd5, 16'h0000, 0, 0);
    add(0, 16'h0000, 0, 4'd5, 16'h0000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].rq, vecs[i].d);
      check($sformatf("vec%0d", i),
            {10'd0, sel, gnt, busy, timeout},
            {10'd0, vecs[i].e_sel, vecs[i].e_gnt, vecs[i].e_busy, vecs[i].e_to});
    end

    // ---- all requesting, done each tenure: ascending order with wrap ----
    step(1, 16'h0000, 0);
    step(0, 16'h0000, 0);
    for (int k = 0; k <= 16; k++) begin
      step(0, 16'hFFFF, 0);
      check($sformatf("rr_sel%0d", k), {28'd0, sel}, k % 16);
      check($sformatf("rr_gnt%0d", k), {16'd0, gnt}, 32'd1 << (k % 16));
      step(0, 16'hFFFF, 1);
      check("rr_gap", {16'd0, gnt}, 32'd0);
      step(0, 16'hFFFF, 0);
    end

    // ---- wrap-around priority: pointer 15, requests 15 and 0 ----
    step(1, 16'h0000, 0);
    step(0, 16'h4000, 0);
    check("wrap_own14", {28'd0, sel}, 32'd14);
    step(0, 16'h4000, 1);
    step(0, 16'h8001, 0);
    step(0, 16'h8001, 0);
    check("wrap_first15", {16'd0, gnt}, 32'h8000);
    step(0, 16'h8001, 1);
    step(0, 16'h8001, 0);
    step(0, 16'h8001, 0);
    check("wrap_then0", {16'd0, gnt}, 32'h0001);

    // ---- reset in the middle of a tenure ----
    step(1, 16'h0000, 0);
    step(0, 16'h0008, 0);
    step(0, 16'h0008, 0);
    step(1, 16'h0008, 0);
    check("midrst_out", {10'd0, sel, gnt, busy, timeout}, 32'd0);
    step(0, 16'h0008, 0);
    check("midrst_regrant", {11'd0, sel, gnt, busy}, {11'd0, 4'd3, 16'h0008, 1'b1});

    // ---- randomized traffic against the model ----
    begin
      logic [15:0] cur;
      cur = 16'h0000;
      for (int n = 0; n < 4000; n++) begin
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: cur = 16'($urandom);
            1: cur = 16'd1 << $urandom_range(0, 15);
            2: cur = 16'hFFFF;
            default: cur = 16'($urandom) & 16'($urandom) & 16'($urandom);
          endcase
        end
        step(($urandom_range(0, 199) == 0), cur, ($urandom_range(0, 11) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
